online_ccm_test_ctrl: RTL

Sequencer for the overclocked online constant-coefficient multiplier (CCM) test path. It drives a new operand into the CCM, waits a programmable settle window, and captures the redundant CCM result. It checks the result against a conventionally computed golden product and accumulates vector and error counts. It sits between the test-platform host registers and the CCM instance under test.

---
 rtl/online_ccm_test_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/online_ccm_test_ctrl.sv
// online_ccm_test_ctrl
//   Sequencer for the overclocked online constant-coefficient multiplier test
//   path. It launches an operand into the CCM, waits a programmable settle
//   window, captures the redundant result once, and checks it against the
//   conventionally computed product MULT * X. It counts vectors and errors,
//   and keeps the first failing operand/result pair of the run.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : run start pulse, honoured in IDLE or DONE
//   abort         : returns to IDLE; wins over start
//   mode          : operand source, 0 = LFSR, 1 = counter sweep (latched on start)
//   dut_x         : registered operand to the CCM (signed-digit, {plus,minus} pairs)
//   dut_y         : CCM result, redundant signed digits
//   busy, done    : status (busy in LAUNCH/WAIT/CAPTURE/CHECK, done in DONE)
//   vec_cnt       : vectors checked in the current run
//   err_cnt       : mismatches in the current run, saturating
//   first_err_x/y : operand and captured result of the first mismatch
module online_ccm_test_ctrl #(
  parameter int          STAGE     = 4,
  parameter int          WL_OUT    = 2*(STAGE+5),
  parameter int          MULT      = 14,
  parameter int          SETTLE    = 2,
  parameter int          NUM_VEC   = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  output logic [2*STAGE-1:0]   dut_x,
  input  logic [WL_OUT-1:0]    dut_y,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_cnt,
  output logic [15:0]          err_cnt,
  output logic [2*STAGE-1:0]   first_err_x,
  output logic [WL_OUT-1:0]    first_err_y
);

  localparam int WL_IN = 2*STAGE;
  localparam int YD    = WL_OUT/2;
  // Wide enough for the sign-extended CCM result and for MULT * X exactly.
  localparam int GW    = 34 + STAGE + YD;

  localparam logic signed [GW-1:0] MULT_W    = GW'(MULT);
  localparam logic [7:0]           SETTLE_M1 = 8'(SETTLE-1);
  localparam logic [15:0]          NUM_VEC_W = 16'(NUM_VEC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WL_IN-1:0]   dut_x_q, dut_x_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [WL_IN-1:0]   sweep_q, sweep_d;
  logic               mode_q, mode_d;
  logic [7:0]         settle_q, settle_d;
  logic [WL_OUT-1:0]  y_cap_q, y_cap_d;
  logic [15:0]        vec_cnt_q, vec_cnt_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic [WL_IN-1:0]   first_err_x_q, first_err_x_d;
  logic [WL_OUT-1:0]  first_err_y_q, first_err_y_d;

  // Golden check: split digits into plus/minus magnitudes, value = P - N.
  logic [STAGE-1:0]      x_p, x_n;
  logic [YD-1:0]         y_p, y_n;
  logic signed [GW-1:0]  x_int, y_int, golden;
  logic                  mismatch;

  always_comb begin
    x_p = '0;
    x_n = '0;
    y_p = '0;
    y_n = '0;
    for (int unsigned k = 0; k < STAGE; k++) begin
      x_p[k] = dut_x_q[2*k+1];
      x_n[k] = dut_x_q[2*k];
    end
    for (int unsigned k = 0; k < YD; k++) begin
      y_p[k] = y_cap_q[2*k+1];
      y_n[k] = y_cap_q[2*k];
    end
    x_int    = GW'(x_p) - GW'(x_n);
    y_int    = GW'(y_p) - GW'(y_n);
    golden   = x_int * MULT_W;
    mismatch = (y_int != golden);
  end

  logic        lfsr_fb;
  logic [15:0] vec_inc;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign vec_inc = vec_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    dut_x_d       = dut_x_q;
    lfsr_d        = lfsr_q;
    sweep_d       = sweep_q;
    mode_d        = mode_q;
    settle_d      = settle_q;
    y_cap_d       = y_cap_q;
    vec_cnt_d     = vec_cnt_q;
    err_cnt_d     = err_cnt_q;
    first_err_x_d = first_err_x_q;
    first_err_y_d = first_err_y_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          vec_cnt_d     = '0;
          err_cnt_d     = '0;
          first_err_x_d = '0;
          first_err_y_d = '0;
          lfsr_d        = LFSR_SEED;
          sweep_d       = '0;
          mode_d        = mode;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (mode_q) begin
            dut_x_d = sweep_q;
            sweep_d = sweep_q + WL_IN'(1);
          end else begin
            dut_x_d = lfsr_q[WL_IN-1:0];
            lfsr_d  = {lfsr_q[14:0], lfsr_fb};
          end
          settle_d = SETTLE_M1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          y_cap_d = dut_y;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          vec_cnt_d = vec_inc;
          if (mismatch) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == '0) begin
              first_err_x_d = dut_x_q;
              first_err_y_d = y_cap_q;
            end
          end
          state_d = (vec_inc == NUM_VEC_W) ? S_DONE : S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dut_x_q       <= '0;
      lfsr_q        <= LFSR_SEED;
      sweep_q       <= '0;
      mode_q        <= 1'b0;
      settle_q      <= '0;
      y_cap_q       <= '0;
      vec_cnt_q     <= '0;
      err_cnt_q     <= '0;
      first_err_x_q <= '0;
      first_err_y_q <= '0;
    end else begin
      state_q       <= state_d;
      dut_x_q       <= dut_x_d;
      lfsr_q        <= lfsr_d;
      sweep_q       <= sweep_d;
      mode_q        <= mode_d;
      settle_q      <= settle_d;
      y_cap_q       <= y_cap_d;
      vec_cnt_q     <= vec_cnt_d;
      err_cnt_q     <= err_cnt_d;
      first_err_x_q <= first_err_x_d;
      first_err_y_q <= first_err_y_d;
    end
  end

  assign dut_x       = dut_x_q;
  assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                       (state_q == S_CAPTURE) || (state_q == S_CHECK);
  assign done        = (state_q == S_DONE);
  assign vec_cnt     = vec_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign first_err_x = first_err_x_q;
  assign first_err_y = first_err_y_q;

endmodule
